matrix_alu: RTL and testbench
=============================

Name: matrix_alu

Overview:
- Arithmetic stage directly downstream of the execution stage in the matrix engine.
- Follows the execution stage's 4-bit command/state code.
- Captures two 4x4 matrices of 16-bit elements from the 256-bit data bus.
- Performs the operation selected by the instruction opcode, holds the result, and drives it back onto the data bus when commanded.

Parameters:
- ELEM_W, 16, element width in bits.
- DIM, 4, matrix dimension; matrices are DIM x DIM, bus width DIM*DIM*ELEM_W = 256.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- exe_cmd  input  4  execution-stage state code: 0 read, 1 decode, 2 moveSource1, 3 moveSource2, 4 executeMath, 5 moveDestination
- opcode  input  8  instruction bits [31:24]; sampled when executeMath is accepted
- data_in  input  256  source matrix from memory
- data_out  output  256  result matrix; zero when not driving
- data_out_valid  output  1  data_out holds the result
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse when the result register is updated
- op_error  output  1  last executed opcode was illegal

Behaviour:
- Element layout: element (r,c) occupies bits [16*(4r+c)+15 : 16*(4r+c)].
- Arithmetic: all unsigned, modulo 2^16, truncated with no saturation.
- Reset (reset=0, asynchronous): state IDLE; src_a, src_b, result and cmd_prev cleared to 0; data_out=0; data_out_valid, busy, done, op_error all 0.
- Command acceptance: a command is acted on only in the cycle where exe_cmd differs from cmd_prev (registered every cycle). A held code acts once.
- exe_cmd 2 accepted: src_a <= data_in. Ignored while busy.
- exe_cmd 3 accepted: src_b <= data_in. Ignored while busy.
- exe_cmd 4 accepted while IDLE/DONE: latch opcode, clear op_error, then dispatch on opcode:
  - 0x00 ADD: result = A + B elementwise.
  - 0x01 SUB: result = A - B elementwise.
  - 0x03 TRANSPOSE: result(r,c) = A(c,r).
  - 0x04 SCALE: result = A * B(0,0) elementwise.
  - 0x05 HALT: result unchanged.
  - For all five: result written on the accept edge; done pulses the following cycle (latency 1).
  - 0x02 MULTIPLY: enter MUL, busy=1. Per cycle, 5-bit counter k (0..15) computes element k as sum over i of A(r,i)*B(i,c), with r=k/4, c=k%4, accumulated at 32 bits and truncated to 16. After k=15, result is written, busy=0 and done pulses in the same cycle. Total: 16 cycles from accept to done.
  - Any other opcode: result <= 0, op_error <= 1, done pulses (latency 1).
- exe_cmd 4 while busy: ignored; the multiply continues.
- State machine:
  - IDLE -> EXEC on accepted cmd 4 (non-multiply).
  - IDLE -> MUL on accepted cmd 4 with multiply.
  - EXEC -> DONE after 1 cycle.
  - MUL -> DONE when k=15.
  - DONE -> EXEC/MUL on the next accepted cmd 4; DONE otherwise holds.
  - DONE behaves as IDLE for commands 2/3.
- Output drive: while exe_cmd==5 and state != MUL, data_out = result and data_out_valid=1 (registered, 1 cycle after exe_cmd becomes 5). If exe_cmd==5 arrives during MUL, valid stays 0 until the cycle after done. Whenever exe_cmd != 5, data_out=0 and valid=0.
- Simultaneous events: done and a new cmd 2/3 in the same cycle are both honoured. Sources may be reloaded after accept without affecting an in-flight multiply, which uses private copies latched at accept.
- Reset mid-multiply: the partial result is discarded, all outputs go to reset values, and no done pulse is issued.

Test Plan:
- ADD: A all elements 1, B all 2; cmds 2,3,4 (op 0x00),5 -> done 1 cycle after accept; data_out all elements 0x0003; valid=1.
- SUB wrap: A all 1, B all 2, op 0x01 -> every element 0xFFFF; op_error=0.
- MULTIPLY: A=identity, B elements 0..15; op 0x02 -> busy high 16 cycles, done at cycle 16, result = B. Repeat with A all 2, B all 3 -> all elements 0x0018.
- TRANSPOSE/SCALE: A elements 0..15, op 0x03 -> element(1,0)=1, element(0,1)=4. A all 5, B(0,0)=0x4000, op 0x04 -> all 0x4000 (5*0x4000 = 0x14000, truncated).
- Illegal opcode 0x07 -> result 0, op_error=1, done pulses. A following ADD clears op_error.
- Robustness:
  - exe_cmd held at 4 for 5 cycles: exactly one done.
  - exe_cmd 5 issued mid-multiply: valid rises only after done.
  - reset asserted at multiply cycle 8: all outputs 0 immediately, no done.

Source files
------------

// File: rtl/matrix_alu_if.sv
// Matrix ALU bus: links the execution stage (master) to the matrix ALU (slave).
//   exe_cmd        : execution-stage state code (master -> slave)
//   opcode         : instruction bits [31:24] (master -> slave)
//   data_in        : source matrix from memory (master -> slave)
//   data_out       : result matrix, zero when not driving (slave -> master)
//   data_out_valid : data_out holds the result (slave -> master)
//   busy           : multiply in progress (slave -> master)
//   done           : one-cycle pulse when the result register is updated (slave -> master)
//   op_error       : last executed opcode was illegal (slave -> master)
interface matrix_alu_if #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4
);
  localparam int unsigned BUS_W = DIM * DIM * ELEM_W;

  logic [3:0]       exe_cmd;
  logic [7:0]       opcode;
  logic [BUS_W-1:0] data_in;
  logic [BUS_W-1:0] data_out;
  logic             data_out_valid;
  logic             busy;
  logic             done;
  logic             op_error;

  modport master (
    output exe_cmd, opcode, data_in,
    input  data_out, data_out_valid, busy, done, op_error
  );

  modport slave (
    input  exe_cmd, opcode, data_in,
    output data_out, data_out_valid, busy, done, op_error
  );
endinterface

// File: rtl/matrix_alu.sv
// Matrix ALU: captures two DIM x DIM matrices from the data bus, runs the
// opcode-selected elementwise / transpose / scale / multiply operation and
// drives the held result back onto the bus on the moveDestination command.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : matrix_alu_if.slave (command, opcode, data in/out, status)
module matrix_alu #(
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned DIM    = 4
) (
  input  logic        clock,
  input  logic        reset,
  matrix_alu_if.slave bus
);
  localparam int unsigned N     = DIM * DIM;
  localparam int unsigned BUS_W = N * ELEM_W;
  localparam int unsigned IDX_W = $clog2(BUS_W);
  localparam int unsigned ACC_W = 2 * ELEM_W;
  localparam int unsigned K_W   = $clog2(N) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  localparam logic [3:0] CMD_SRC1 = 4'd2;
  localparam logic [3:0] CMD_SRC2 = 4'd3;
  localparam logic [3:0] CMD_MATH = 4'd4;
  localparam logic [3:0] CMD_DEST = 4'd5;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_TRN  = 8'h03;
  localparam logic [7:0] OP_SCL  = 8'h04;
  localparam logic [7:0] OP_HALT = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cmd_prev_q, cmd_prev_d;
  logic [BUS_W-1:0] src_a_q, src_a_d;
  logic [BUS_W-1:0] src_b_q, src_b_d;
  logic [BUS_W-1:0] mul_a_q, mul_a_d;
  logic [BUS_W-1:0] mul_b_q, mul_b_d;
  logic [BUS_W-1:0] acc_q, acc_d;
  logic [BUS_W-1:0] result_q, result_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             op_error_q, op_error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             data_out_valid_q, data_out_valid_d;
  logic [BUS_W-1:0] data_out_q, data_out_d;

  logic             accept;
  logic             start;
  logic [BUS_W-1:0] add_res, sub_res, trn_res, scl_res;
  logic [ELEM_W-1:0] dot;

  // Bit offset of element (r,c) in a flattened matrix.
  function automatic logic [IDX_W-1:0] off(input int unsigned r, input int unsigned c);
    return IDX_W'(ELEM_W * (DIM * r + c));
  endfunction

  function automatic logic [ELEM_W-1:0] elem(input logic [BUS_W-1:0] m,
                                             input int unsigned r, input int unsigned c);
    return m[off(r, c) +: ELEM_W];
  endfunction

  // A command acts only on the cycle its code first appears.
  assign accept = (bus.exe_cmd != cmd_prev_q);
  assign start  = accept && (bus.exe_cmd == CMD_MATH) &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Single-cycle operations, all computed from the live source registers.
  always_comb begin : single_cycle_ops
    add_res = '0;
    sub_res = '0;
    trn_res = '0;
    scl_res = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      for (int unsigned c = 0; c < DIM; c++) begin
        add_res[off(r, c) +: ELEM_W] = elem(src_a_q, r, c) + elem(src_b_q, r, c);
        sub_res[off(r, c) +: ELEM_W] = elem(src_a_q, r, c) - elem(src_b_q, r, c);
        trn_res[off(r, c) +: ELEM_W] = elem(src_a_q, c, r);
        scl_res[off(r, c) +: ELEM_W] = elem(src_a_q, r, c) * elem(src_b_q, 0, 0);
      end
    end
  end

  // One dot product per multiply cycle: element k = row(k/DIM) . col(k%DIM).
  always_comb begin : mul_dot
    int unsigned      row;
    int unsigned      col;
    logic [ACC_W-1:0] sum;
    row = 32'(k_q) / DIM;
    col = 32'(k_q) % DIM;
    sum = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      sum = sum + ACC_W'(elem(mul_a_q, row, i)) * ACC_W'(elem(mul_b_q, i, col));
    end
    dot = sum[ELEM_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (bus.opcode == OP_MUL) ? ST_MUL : ST_EXEC;
      ST_EXEC:          state_d = ST_DONE;
      ST_MUL:           if (k_q == K_LAST) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; all registered.
  always_comb begin : fsm_outputs
    busy_d           = (state_d == ST_MUL);
    done_d           = (state_q == ST_EXEC) || ((state_q == ST_MUL) && (k_q == K_LAST));
    data_out_valid_d = (bus.exe_cmd == CMD_DEST) && (state_q != ST_MUL);
    data_out_d       = data_out_valid_d ? result_q : '0;
  end

  // Datapath next values.
  always_comb begin : datapath_next
    cmd_prev_d = bus.exe_cmd;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    k_d        = k_q;
    op_error_d = op_error_q;

    if (accept && (state_q != ST_MUL)) begin
      if (bus.exe_cmd == CMD_SRC1) src_a_d = bus.data_in;
      if (bus.exe_cmd == CMD_SRC2) src_b_d = bus.data_in;
    end

    if (start) begin
      op_error_d = 1'b0;
      case (bus.opcode)
        OP_ADD:  result_d = add_res;
        OP_SUB:  result_d = sub_res;
        OP_TRN:  result_d = trn_res;
        OP_SCL:  result_d = scl_res;
        OP_HALT: result_d = result_q;
        OP_MUL: begin
          // Private copies so later source loads cannot disturb the multiply.
          mul_a_d = src_a_q;
          mul_b_d = src_b_q;
          acc_d   = '0;
          k_d     = '0;
        end
        default: begin
          result_d   = '0;
          op_error_d = 1'b1;
        end
      endcase
    end

    if (state_q == ST_MUL) begin
      acc_d[off(0, 32'(k_q)) +: ELEM_W] = dot;
      if (k_q == K_LAST) result_d = acc_d;
      else               k_d      = k_q + K_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_prev_q       <= '0;
      src_a_q          <= '0;
      src_b_q          <= '0;
      mul_a_q          <= '0;
      mul_b_q          <= '0;
      acc_q            <= '0;
      result_q         <= '0;
      k_q              <= '0;
      op_error_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      data_out_valid_q <= 1'b0;
      data_out_q       <= '0;
    end else begin
      cmd_prev_q       <= cmd_prev_d;
      src_a_q          <= src_a_d;
      src_b_q          <= src_b_d;
      mul_a_q          <= mul_a_d;
      mul_b_q          <= mul_b_d;
      acc_q            <= acc_d;
      result_q         <= result_d;
      k_q              <= k_d;
      op_error_q       <= op_error_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      data_out_valid_q <= data_out_valid_d;
      data_out_q       <= data_out_d;
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.op_error       = op_error_q;

endmodule

// File: tb/tb_matrix_alu.sv
// Testbench for matrix_alu: directed command sequences with a behavioural
// matrix model compared against the DUT every cycle, plus literal checks.
module tb_matrix_alu;
  localparam int N = 16;
  typedef logic [15:0] mat_t [N];

  logic clock = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  matrix_alu_if bus_if ();

  matrix_alu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  // Behavioural model state.
  mat_t         m_a, m_b, m_res, m_pend;
  logic [3:0]   m_prev;
  int           m_left;
  logic         m_pending, m_busy, m_done, m_valid, m_err;
  logic [255:0] m_out;

  function automatic logic [255:0] pack(input mat_t m);
    logic [255:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = m[i];
    return v;
  endfunction

  function automatic mat_t unpack(input logic [255:0] v);
    mat_t m;
    for (int i = 0; i < N; i++) m[i] = v[i*16 +: 16];
    return m;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] x);
    logic [255:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = x;
    return v;
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = 16'(i);
    return v;
  endfunction

  function automatic logic [255:0] ident();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[(i*5)*16 +: 16] = 16'd1;
    return v;
  endfunction

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t   r;
    longint s;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        s = 0;
        for (int i = 0; i < 4; i++) s += longint'(a[row*4+i]) * longint'(b[i*4+col]);
        r[row*4+col] = s[15:0];
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_pend[i] = '0;
    end
    m_prev = '0; m_left = 0; m_pending = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_out = '0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    logic       in_mul;
    logic       acc;
    logic [3:0] cmd;
    if (!reset) begin
      model_reset();
      return;
    end
    cmd     = bus_if.exe_cmd;
    in_mul  = (m_left != 0);
    acc     = (cmd != m_prev);
    m_valid = (cmd == 4'd5) && !in_mul;
    m_out   = m_valid ? pack(m_res) : '0;
    m_done  = m_pending;
    m_pending = 1'b0;
    if (in_mul) begin
      m_left--;
      if (m_left == 0) begin
        m_res  = m_pend;
        m_done = 1'b1;
      end
    end
    if (acc && !in_mul) begin
      if (cmd == 4'd2) m_a = unpack(bus_if.data_in);
      if (cmd == 4'd3) m_b = unpack(bus_if.data_in);
      if (cmd == 4'd4) begin
        m_err = 1'b0;
        case (bus_if.opcode)
          8'h00: for (int i = 0; i < N; i++) m_res[i] = m_a[i] + m_b[i];
          8'h01: for (int i = 0; i < N; i++) m_res[i] = m_a[i] - m_b[i];
          8'h02: begin m_pend = matmul(m_a, m_b); m_left = 16; end
          8'h03: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m_res[r*4+c] = m_a[c*4+r];
          8'h04: for (int i = 0; i < N; i++) m_res[i] = m_a[i] * m_b[0];
          8'h05: ;
          default: begin
            for (int i = 0; i < N; i++) m_res[i] = '0;
            m_err = 1'b1;
          end
        endcase
        if (bus_if.opcode != 8'h02) m_pending = 1'b1;
      end
    end
    m_busy = (m_left != 0);
    m_prev = cmd;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("data_out", bus_if.data_out, m_out);
      check("valid", 256'(bus_if.data_out_valid), 256'(m_valid));
      check("busy", 256'(bus_if.busy), 256'(m_busy));
      check("done", 256'(bus_if.done), 256'(m_done));
      check("op_error", 256'(bus_if.op_error), 256'(m_err));
    end
  end

  task automatic step(input logic [3:0] cmd, input logic [7:0] op, input logic [255:0] din);
    bus_if.exe_cmd = cmd;
    bus_if.opcode  = op;
    bus_if.data_in = din;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic read_check(input string name, input logic [255:0] exp);
    step(4'd5, 8'h00, '0);
    check({name, "_data"}, bus_if.data_out, exp);
    check({name, "_valid"}, 256'(bus_if.data_out_valid), 256'(1));
    step(4'd0, 8'h00, '0);
  endtask

  // Accept a multiply and check busy length and done position.
  task automatic mul_run(input string name);
    int busy_cnt;
    int done_at;
    step(4'd4, 8'h02, '0);
    busy_cnt = bus_if.busy ? 1 : 0;
    done_at  = 0;
    for (int j = 1; j <= 16; j++) begin
      step(4'd4, 8'h02, '0);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done && done_at == 0) done_at = j;
    end
    check({name, "_busy_cycles"}, 256'(busy_cnt), 256'(16));
    check({name, "_done_at"}, 256'(done_at), 256'(16));
  endtask

  initial begin
    logic [255:0] b_scl;
    int cnt, done_at, valid_at;

    reset = 1'b1;
    bus_if.exe_cmd = '0;
    bus_if.opcode  = '0;
    bus_if.data_in = '0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("reset_data", bus_if.data_out, '0);
    check("reset_status", 256'({bus_if.data_out_valid, bus_if.busy, bus_if.done, bus_if.op_error}), '0);
    chk_en = 1'b1;
    step(4'd0, 8'h00, '0);
    reset = 1'b1;
    step(4'd0, 8'h00, '0);

    // ADD
    step(4'd2, 8'h00, fill(16'd1));
    step(4'd3, 8'h00, fill(16'd2));
    step(4'd4, 8'h00, '0);
    step(4'd5, 8'h00, '0);
    check("add_done", 256'(bus_if.done), 256'(1));
    check("add_data", bus_if.data_out, fill(16'h0003));
    check("add_valid", 256'(bus_if.data_out_valid), 256'(1));
    step(4'd0, 8'h00, '0);

    // SUB wraps
    step(4'd4, 8'h01, '0);
    read_check("sub", fill(16'hFFFF));
    check("sub_err", 256'(bus_if.op_error), 256'(0));

    // MULTIPLY identity x ramp, then reload sources in the done cycle
    step(4'd2, 8'h00, ident());
    step(4'd3, 8'h00, ramp());
    mul_run("mul_id");
    step(4'd2, 8'h00, fill(16'd2));
    step(4'd3, 8'h00, fill(16'd3));
    read_check("mul_id", ramp());
    mul_run("mul_23");
    read_check("mul_23", fill(16'h0018));

    // TRANSPOSE
    step(4'd2, 8'h00, ramp());
    step(4'd4, 8'h03, '0);
    step(4'd5, 8'h00, '0);
    check("trn_e10", 256'(bus_if.data_out[79:64]), 256'(1));
    check("trn_e01", 256'(bus_if.data_out[31:16]), 256'(4));
    step(4'd0, 8'h00, '0);

    // SCALE truncates, then HALT keeps result
    b_scl = fill(16'd7);
    b_scl[15:0] = 16'h4000;
    step(4'd2, 8'h00, fill(16'd5));
    step(4'd3, 8'h00, b_scl);
    step(4'd4, 8'h04, '0);
    read_check("scale", fill(16'h4000));
    step(4'd4, 8'h05, '0);
    read_check("halt", fill(16'h4000));

    // Illegal opcode, then ADD clears op_error
    step(4'd4, 8'h07, '0);
    step(4'd5, 8'h00, '0);
    check("ill_err", 256'(bus_if.op_error), 256'(1));
    check("ill_done", 256'(bus_if.done), 256'(1));
    check("ill_data", bus_if.data_out, '0);
    step(4'd0, 8'h00, '0);
    step(4'd4, 8'h00, '0);
    step(4'd5, 8'h00, '0);
    check("clr_err", 256'(bus_if.op_error), 256'(0));
    step(4'd0, 8'h00, '0);

    // exe_cmd held at 4: exactly one done
    cnt = 0;
    for (int j = 0; j < 5; j++) begin
      step(4'd4, 8'h00, '0);
      if (bus_if.done) cnt++;
    end
    step(4'd0, 8'h00, '0);
    if (bus_if.done) cnt++;
    check("held_done_count", 256'(cnt), 256'(1));

    // exe_cmd 5 mid-multiply: valid only the cycle after done
    step(4'd4, 8'h02, '0);
    done_at = 0;
    valid_at = 0;
    for (int j = 1; j <= 20; j++) begin
      step((j < 5) ? 4'd4 : 4'd5, 8'h02, '0);
      if (bus_if.done && done_at == 0) done_at = j;
      if (bus_if.data_out_valid && valid_at == 0) valid_at = j;
    end
    check("mid5_done_at", 256'(done_at), 256'(16));
    check("mid5_valid_at", 256'(valid_at), 256'(17));
    step(4'd0, 8'h00, '0);

    // Reset at multiply cycle 8
    step(4'd4, 8'h02, '0);
    repeat (8) step(4'd4, 8'h02, '0);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_mid_data", bus_if.data_out, '0);
    check("rst_mid_status", 256'({bus_if.data_out_valid, bus_if.busy, bus_if.done, bus_if.op_error}), '0);
    step(4'd0, 8'h00, '0);
    step(4'd0, 8'h00, '0);
    reset = 1'b1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(4'd0, 8'h00, '0);
      if (bus_if.done) cnt++;
    end
    check("rst_no_done", 256'(cnt), 256'(0));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
